// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory; each access runs IDLE -> ACCESS -> DONE.
// Define ARB_ROUND_ROBIN_EN for alternating priority on simultaneous requests; otherwise r0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [2:0] LAST_CNT = 3'(MEM_LAT);

    state_t            state_q, state_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              pick;

`ifdef ARB_ROUND_ROBIN_EN
    // ptr_q holds the last winner; on a tie the other requester is served.
    logic ptr_q, ptr_d;
    assign pick = (r0_req && r1_req) ? ~ptr_q : ~r0_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b1;
        else     ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && (r0_req || r1_req)) ptr_d = pick;
    end
`else
    assign pick = ~r0_req;
`endif

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    win_d   = pick;
                    we_d    = pick ? r1_we : r0_we;
                    addr_d  = pick ? r1_addr : r0_addr;
                    wdata_d = pick ? r1_wdata : r0_wdata;
                    cnt_d   = 3'd0;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    if (win_q) rdata1_d = mem_rdata;
                    else       rdata0_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= 3'd0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Memory strobes decode straight from state so an async reset drops them at once.
    assign mem_addr  = (state_q == ACCESS) ? addr_q : '0;
    assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
    assign mem_wr    = (state_q == ACCESS) && we_q;
    assign mem_rd    = (state_q == ACCESS) && !we_q;
    assign r0_gnt    = gnt0_q;
    assign r1_gnt    = gnt1_q;
    assign r0_done   = (state_q == DONE) && !win_q;
    assign r1_done   = (state_q == DONE) && win_q;
    assign r0_rdata  = rdata0_q;
    assign r1_rdata  = rdata1_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a MEM_LAT=0 instance for most scenarios plus a MEM_LAT=3 instance.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [6:0]  r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r0_done, r1_gnt, r1_done;
    logic [31:0] r0_rdata, r1_rdata;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, busy;

    logic        b_r0_req, b_r1_req;
    logic [6:0]  b_r0_addr;
    logic        b_r0_gnt, b_r0_done, b_r1_gnt, b_r1_done;
    logic [31:0] b_r0_rdata, b_r1_rdata;
    logic [6:0]  b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata;
    logic        b_mem_rd, b_mem_wr, b_busy;

    logic [31:0] mem     [128];
    logic [31:0] exp_mem [128];
    logic [31:0] bmem    [128];
    logic [31:0] sb_q    [$];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .MEM_LAT(0)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .MEM_LAT(3)) dut_lat3 (
        .clk(clk), .rst(rst),
        .r0_req(b_r0_req), .r0_we(1'b0), .r0_addr(b_r0_addr), .r0_wdata(32'h0),
        .r0_gnt(b_r0_gnt), .r0_done(b_r0_done), .r0_rdata(b_r0_rdata),
        .r1_req(b_r1_req), .r1_we(1'b0), .r1_addr(7'h0), .r1_wdata(32'h0),
        .r1_gnt(b_r1_gnt), .r1_done(b_r1_done), .r1_rdata(b_r1_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Data memory models: write on the clock edge, combinational read.
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;
    assign mem_rdata   = mem[mem_addr];
    assign b_mem_rdata = bmem[b_mem_addr];

    // Drives one access on the MEM_LAT=0 instance and measures it; the callers do the comparisons.
    task automatic run_access(input int id, input bit we, input logic [6:0] addr,
                              input logic [31:0] wdata, input logic [6:0] addr_after,
                              output int gnt_cyc, output int done_cyc, output int strobes,
                              output int strobe_first, output bit addr_bad,
                              output logic [31:0] rdata);
        gnt_cyc = -1; done_cyc = -1; strobes = 0; strobe_first = -1; addr_bad = 1'b0;
        rdata = 32'hx;
        @(negedge clk);
        if (id == 0) begin r0_req = 1; r0_we = we; r0_addr = addr; r0_wdata = wdata; end
        else         begin r1_req = 1; r1_we = we; r1_addr = addr; r1_wdata = wdata; end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if ((id == 0 && r0_gnt) || (id == 1 && r1_gnt)) begin
                gnt_cyc = c;
                if (id == 0) r0_addr = addr_after; else r1_addr = addr_after;
            end
            if (mem_rd || mem_wr) begin
                strobes++;
                if (strobe_first < 0) strobe_first = c;
                if (mem_addr !== addr) addr_bad = 1'b1;
            end
            if ((id == 0 && r0_done) || (id == 1 && r1_done)) begin
                done_cyc = c;
                rdata = (id == 0) ? r0_rdata : r1_rdata;
                break;
            end
        end
        r0_req = 0; r1_req = 0;
        $display("txn r%0d %s addr=%h wdata=%h gnt@%0d done@%0d rdata=%h",
                 id, we ? "WR" : "RD", addr, wdata, gnt_cyc, done_cyc, rdata);
    endtask

    task automatic test_reset;
        logic [177:0] outs;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            outs = {r0_gnt, r0_done, r0_rdata, r1_gnt, r1_done, r1_rdata,
                    mem_addr, mem_wdata, mem_rd, mem_wr, busy};
            checks++;
            if (outs !== '0) $display("FAIL reset_outputs cycle %0d: got %h want 0", i, outs);
            else passed++;
        end
    endtask

    task automatic test_write_read;
        int g, d, s, f; bit ab; logic [31:0] rd, expv;
        run_access(1, 1'b1, 7'h05, 32'hDEADBEEF, 7'h05, g, d, s, f, ab, rd);
        exp_mem[5] = 32'hDEADBEEF;
        checks++; if (g !== 1) $display("FAIL wr_gnt_cycle: got %0d want 1", g); else passed++;
        checks++; if (s !== 1 || f !== 1) $display("FAIL wr_strobe: got count %0d first %0d want 1/1", s, f); else passed++;
        checks++; if (d !== 2) $display("FAIL wr_done_cycle: got %0d want 2", d); else passed++;
        checks++; if (rd !== 32'h0) $display("FAIL wr_rdata_unchanged: got %h want 0", rd); else passed++;
        sb_q.push_back(exp_mem[5]);
        run_access(0, 1'b0, 7'h05, 32'h0, 7'h05, g, d, s, f, ab, rd);
        checks++; if (g !== 1) $display("FAIL rd_gnt_cycle: got %0d want 1", g); else passed++;
        checks++; if (d !== 2) $display("FAIL rd_done_cycle: got %0d want 2", d); else passed++;
        expv = sb_q.pop_front();
        checks++; if (rd !== expv) $display("FAIL rd_rdata: got %h want %h", rd, expv); else passed++;
    endtask

    task automatic test_addr_stable;
        int g, d, s, f; bit ab; logic [31:0] rd, expv;
        run_access(1, 1'b1, 7'h10, 32'hA1B2C3D4, 7'h10, g, d, s, f, ab, rd);
        exp_mem[7'h10] = 32'hA1B2C3D4;
        run_access(1, 1'b1, 7'h20, 32'h0BADF00D, 7'h20, g, d, s, f, ab, rd);
        exp_mem[7'h20] = 32'h0BADF00D;
        checks++; if (d !== 2) $display("FAIL preload_done: got %0d want 2", d); else passed++;
        sb_q.push_back(exp_mem[7'h10]);
        run_access(0, 1'b0, 7'h10, 32'h0, 7'h20, g, d, s, f, ab, rd);
        checks++; if (ab !== 1'b0 || s !== 1) $display("FAIL addr_latched: got bad=%0d strobes=%0d want 0/1", ab, s); else passed++;
        expv = sb_q.pop_front();
        checks++; if (rd !== expv) $display("FAIL addr_latched_rdata: got %h want %h", rd, expv); else passed++;
        checks++; if (r1_rdata !== 32'h0) $display("FAIL loser_rdata: got %h want 0", r1_rdata); else passed++;
    endtask

    task automatic test_mem_lat3;
        int rd_cnt = 0, wr_cnt = 0, done_cyc = -1; bit ab = 0; logic [31:0] expv, got;
        got = 32'hx;
        sb_q.push_back(bmem[7'h33]);
        @(negedge clk);
        b_r0_req = 1; b_r0_addr = 7'h33;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (b_r0_gnt) b_r0_addr = 7'h44;
            if (b_mem_rd) begin rd_cnt++; if (b_mem_addr !== 7'h33) ab = 1; end
            if (b_mem_wr) wr_cnt++;
            if (b_r0_done) begin done_cyc = c; got = b_r0_rdata; break; end
        end
        b_r0_req = 0;
        $display("txn lat3 r0 RD addr=33 rd_cycles=%0d done@%0d rdata=%h", rd_cnt, done_cyc, got);
        checks++; if (rd_cnt !== 4 || wr_cnt !== 0) $display("FAIL lat3_strobe: got rd=%0d wr=%0d want 4/0", rd_cnt, wr_cnt); else passed++;
        checks++; if (ab !== 1'b0) $display("FAIL lat3_addr_stable: got unstable want stable"); else passed++;
        checks++; if (done_cyc !== 5) $display("FAIL lat3_done_cycle: got %0d want 5", done_cyc); else passed++;
        expv = sb_q.pop_front();
        checks++; if (got !== expv) $display("FAIL lat3_rdata: got %h want %h", got, expv); else passed++;
    endtask

    task automatic test_back_to_back;
        int rem [2];
        bit raise [2];
        int order [$];
        int exp_order [4];
        logic [31:0] expv;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 1, 1};
`endif
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        rem = '{2, 2}; raise = '{0, 0};
        @(negedge clk);
        r0_req = 1; r0_we = 0; r0_addr = 7'h05;
        r1_req = 1; r1_we = 0; r1_addr = 7'h10;
        for (int c = 0; c < 60 && (rem[0] > 0 || rem[1] > 0); c++) begin
            @(negedge clk);
            if (raise[0]) begin r0_req = 1; raise[0] = 0; end
            if (raise[1]) begin r1_req = 1; raise[1] = 0; end
            if (r0_gnt) begin order.push_back(0); sb_q.push_back(exp_mem[7'h05]); end
            if (r1_gnt) begin order.push_back(1); sb_q.push_back(exp_mem[7'h10]); end
            if (r0_done || r1_done) begin
                expv = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
                checks++;
                if (r0_done) begin
                    if (r0_rdata !== expv) $display("FAIL b2b_r0_rdata: got %h want %h", r0_rdata, expv); else passed++;
                    r0_req = 0; rem[0]--; if (rem[0] > 0) raise[0] = 1;
                    $display("txn b2b r0 RD done rdata=%h", r0_rdata);
                end else begin
                    if (r1_rdata !== expv) $display("FAIL b2b_r1_rdata: got %h want %h", r1_rdata, expv); else passed++;
                    r1_req = 0; rem[1]--; if (rem[1] > 0) raise[1] = 1;
                    $display("txn b2b r1 RD done rdata=%h", r1_rdata);
                end
            end
        end
        r0_req = 0; r1_req = 0;
        checks++; if (order.size() !== 4) $display("FAIL b2b_grant_count: got %0d want 4", order.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= order.size()) $display("FAIL b2b_order[%0d]: got none want r%0d", i, exp_order[i]);
            else if (order[i] !== exp_order[i]) $display("FAIL b2b_order[%0d]: got r%0d want r%0d", i, order[i], exp_order[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_access;
        int bad_done = 0, bad_busy = 0;
        @(negedge clk);
        r1_req = 1; r1_we = 1; r1_addr = 7'h09; r1_wdata = 32'h12345678;
        @(negedge clk);
        checks++; if (mem_wr !== 1'b1) $display("FAIL midrst_wr_before: got %b want 1", mem_wr); else passed++;
        #1 rst = 1;
        #1;
        checks++; if (mem_wr !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_immediate: got wr=%b busy=%b want 0/0", mem_wr, busy); else passed++;
        r1_req = 0;
        repeat (2) begin @(negedge clk); if (r1_done) bad_done++; end
        rst = 0;
        repeat (4) begin @(negedge clk); if (r1_done) bad_done++; if (busy) bad_busy++; end
        $display("txn midrst r1 WR addr=09 aborted");
        checks++; if (bad_done !== 0) $display("FAIL midrst_no_done: got %0d done pulses want 0", bad_done); else passed++;
        checks++; if (bad_busy !== 0) $display("FAIL midrst_idle: got %0d busy cycles want 0", bad_busy); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 32'h0; exp_mem[i] = 32'h0; bmem[i] = 32'hC0DE0000 | 32'(i);
        end
        rst = 1;
        r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
        b_r0_req = 0; b_r1_req = 0; b_r0_addr = '0;
        test_reset();
        test_write_read();
        test_addr_stable();
        test_mem_lat3();
        test_back_to_back();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
